// File: rtl/alu_pkg.sv
// Shared types for the sequential integer ALU: function codes, FSM states, default widths.
package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT      = 32;
  localparam int ALU_FUNC_WIDTH_DEFAULT = 5;

  typedef enum logic [4:0] {
    ALU_NOOP = 5'd0,  ALU_ADD  = 5'd1,  ALU_SUB  = 5'd2,  ALU_MUL  = 5'd3,
    ALU_DIV  = 5'd4,  ALU_MOD  = 5'd5,  ALU_OR   = 5'd6,  ALU_AND  = 5'd7,
    ALU_NAND = 5'd8,  ALU_XOR  = 5'd9,  ALU_INV  = 5'd10, ALU_LNOT = 5'd11,
    ALU_LOR  = 5'd12, ALU_LAND = 5'd13, ALU_SHL  = 5'd14, ALU_SHR  = 5'd15,
    ALU_SHL1 = 5'd16, ALU_SHR1 = 5'd17, ALU_INC  = 5'd18, ALU_DEC  = 5'd19,
    ALU_ZERO = 5'd20, ALU_ONE  = 5'd21, ALU_MAX  = 5'd22
  } aluf_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_iter_div.sv
// Iterative restoring divider, one quotient bit per cycle over WIDTH cycles.
// With ALU_ITER_MUL_EN defined it also runs a WIDTH-cycle shift-add multiply.
module alu_iter_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_ITER_MUL_EN
  input  logic             mul,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_nxt;

  // Divisor 0 falls out naturally: every step subtracts nothing, giving an
  // all-ones quotient and a remainder equal to the shifted-in dividend.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_sub     = w_rem_sh[WIDTH-1:0] - r_dvs;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

`ifdef ALU_ITER_MUL_EN
  logic             r_mul;
  logic [WIDTH-1:0] w_prod_nxt;

  // Multiplier bits are consumed MSB-first from r_quo; the product builds in r_rem.
  assign w_prod_nxt = {r_rem[WIDTH-2:0], 1'b0} + (r_quo[WIDTH-1] ? r_dvs : '0);
  assign w_rem_nxt  = r_mul ? w_prod_nxt : (w_ge ? w_sub : w_rem_sh[WIDTH-1:0]);
  assign quotient   = r_mul ? w_prod_nxt : w_quo_nxt;
`else
  assign w_rem_nxt  = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
  assign quotient   = w_quo_nxt;
`endif

  assign remainder = w_rem_nxt;
  // Outputs carry the final step combinationally so the caller captures on the last count.
  assign done      = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
`ifdef ALU_ITER_MUL_EN
      r_mul <= 1'b0;
`endif
    end else if (start) begin
      r_cnt <= CW'(WIDTH);
      r_rem <= '0;
      r_quo <= dividend;
      r_dvs <= divisor;
`ifdef ALU_ITER_MUL_EN
      r_mul <= mul;
`endif
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

endmodule

// File: rtl/int_alu_seq.sv
// Registered integer ALU with valid/ready handshakes, accumulator and iterative DIV/MOD.
// Define ALU_ITER_MUL_EN to route MUL through the multi-cycle path as well.
//
// state | meaning
// IDLE  | no result held, ready for an operation
// BUSY  | iterative divide/multiply running, inputs blocked
// HOLD  | result held on s/co until out_ready
module int_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH_DEFAULT,
  parameter int FUNC_WIDTH = ALU_FUNC_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  ci,
  input  logic [FUNC_WIDTH-1:0] f,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      s,
  output logic                  co,
  output logic                  busy
);

  alu_state_t       r_state;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_acc;
  logic             r_co;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_mod;

  logic             w_accept;
  logic             w_multi;
  logic             w_big_shift;
  logic [WIDTH-1:0] w_res;
  logic             w_co;
  logic             w_done;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign in_ready    = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_big_shift = (b >= WIDTH'(WIDTH));

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign co        = r_co;
  assign busy      = r_busy;

  always_comb begin
    w_res   = '0;
    w_co    = 1'b0;
    w_multi = 1'b0;
    case (f)
      FUNC_WIDTH'(ALU_NOOP): w_res = r_acc;
      FUNC_WIDTH'(ALU_ADD):  {w_co, w_res} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
      FUNC_WIDTH'(ALU_SUB):  {w_co, w_res} = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(ci);
`ifdef ALU_ITER_MUL_EN
      FUNC_WIDTH'(ALU_MUL):  w_multi = 1'b1;
`else
      FUNC_WIDTH'(ALU_MUL):  w_res = a * b;
`endif
      FUNC_WIDTH'(ALU_DIV):  w_multi = 1'b1;
      FUNC_WIDTH'(ALU_MOD):  w_multi = 1'b1;
      FUNC_WIDTH'(ALU_OR):   w_res = a | b;
      FUNC_WIDTH'(ALU_AND):  w_res = a & b;
      FUNC_WIDTH'(ALU_NAND): w_res = ~(a & b);
      FUNC_WIDTH'(ALU_XOR):  w_res = a ^ b;
      FUNC_WIDTH'(ALU_INV):  w_res = ~a;
      FUNC_WIDTH'(ALU_LNOT): w_res = WIDTH'(a == '0);
      FUNC_WIDTH'(ALU_LOR):  w_res = WIDTH'((a != '0) || (b != '0));
      FUNC_WIDTH'(ALU_LAND): w_res = WIDTH'((a != '0) && (b != '0));
      FUNC_WIDTH'(ALU_SHL):  w_res = w_big_shift ? '0 : (a << b);
      FUNC_WIDTH'(ALU_SHR):  w_res = w_big_shift ? '0 : (a >> b);
      FUNC_WIDTH'(ALU_SHL1): w_res = a << 1;
      FUNC_WIDTH'(ALU_SHR1): w_res = a >> 1;
      FUNC_WIDTH'(ALU_INC):  {w_co, w_res} = {1'b0, r_acc} + (WIDTH+1)'(1);
      FUNC_WIDTH'(ALU_DEC):  {w_co, w_res} = {1'b0, r_acc} - (WIDTH+1)'(1);
      FUNC_WIDTH'(ALU_ZERO): w_res = '0;
      FUNC_WIDTH'(ALU_ONE):  w_res = WIDTH'(1);
      FUNC_WIDTH'(ALU_MAX):  w_res = '1;
      default:               w_res = r_acc;
    endcase
  end

  alu_iter_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_accept && w_multi),
`ifdef ALU_ITER_MUL_EN
    .mul       (f == FUNC_WIDTH'(ALU_MUL)),
`endif
    .dividend  (a),
    .divisor   (b),
    .done      (w_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_co        <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_mod       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if ((r_state == HOLD) && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            if (w_multi) begin
              r_state     <= BUSY;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
              r_mod       <= (f == FUNC_WIDTH'(ALU_MOD));
            end else begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_s         <= w_res;
              r_co        <= w_co;
              r_acc       <= w_res;
            end
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state     <= HOLD;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_s         <= r_mod ? w_rem : w_quo;
            r_co        <= 1'b0;
            r_acc       <= r_mod ? w_rem : w_quo;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_alu_seq.sv
// Bench for int_alu_seq: directed scenarios with literal results plus randomized
// traffic compared each cycle against a transaction-level reference model.
module tb_int_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ci;
  logic [4:0]    f;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          co;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  int_alu_seq #(.WIDTH(W), .FUNC_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_valid;
  int           m_wait;
  logic [W-1:0] m_s, m_acc, m_pend;
  bit           m_co;
  bit           m_rdy;
  logic [W-1:0] t_s;
  bit           t_co;

  function automatic bit is_multi(input logic [4:0] fc);
`ifdef ALU_ITER_MUL_EN
    return (fc == ALU_DIV) || (fc == ALU_MOD) || (fc == ALU_MUL);
`else
    return (fc == ALU_DIV) || (fc == ALU_MOD);
`endif
  endfunction

  task automatic ref_op(input logic [4:0] fc, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input bit rci, input logic [W-1:0] racc,
                        output logic [W-1:0] rs, output bit rco);
    longint t;
    rco = 1'b0;
    case (fc)
      ALU_ADD:  begin t = longint'(ra) + longint'(rb) + longint'(rci); rs = t[31:0]; rco = t[32]; end
      ALU_SUB:  begin t = longint'(ra) - longint'(rb) - longint'(rci); rs = t[31:0]; rco = (t < 0); end
      ALU_MUL:  begin t = longint'(ra) * longint'(rb); rs = t[31:0]; end
      ALU_DIV:  rs = (rb == 0) ? 32'hFFFF_FFFF : ra / rb;
      ALU_MOD:  rs = (rb == 0) ? ra : ra % rb;
      ALU_OR:   rs = ra | rb;
      ALU_AND:  rs = ra & rb;
      ALU_NAND: rs = ~(ra & rb);
      ALU_XOR:  rs = ra ^ rb;
      ALU_INV:  rs = ~ra;
      ALU_LNOT: rs = (ra == 0) ? 1 : 0;
      ALU_LOR:  rs = (ra != 0 || rb != 0) ? 1 : 0;
      ALU_LAND: rs = (ra != 0 && rb != 0) ? 1 : 0;
      ALU_SHL:  rs = (rb >= 32) ? 0 : ra << rb;
      ALU_SHR:  rs = (rb >= 32) ? 0 : ra >> rb;
      ALU_SHL1: rs = ra << 1;
      ALU_SHR1: rs = ra >> 1;
      ALU_INC:  begin t = longint'(racc) + 1; rs = t[31:0]; rco = t[32]; end
      ALU_DEC:  begin rs = racc - 1; rco = (racc == 0); end
      ALU_ZERO: rs = 0;
      ALU_ONE:  rs = 1;
      ALU_MAX:  rs = 32'hFFFF_FFFF;
      default:  rs = racc;
    endcase
  endtask

  function automatic bit exp_in_ready();
    return (m_wait == 0) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_wait = 0; m_s = 0; m_co = 0; m_acc = 0; m_pend = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1; m_s = m_pend; m_co = 0; m_acc = m_pend;
      end
    end else begin
      m_rdy = exp_in_ready();
      if (m_valid && out_ready) m_valid = 0;
      if (in_valid && m_rdy) begin
        ref_op(f, a, b, ci, m_acc, t_s, t_co);
        if (is_multi(f)) begin
          m_wait = W; m_pend = t_s; m_valid = 0;
        end else begin
          m_valid = 1; m_s = t_s; m_co = t_co; m_acc = t_s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      check("cmp_out_valid", out_valid, m_valid);
      check("cmp_busy", busy, m_wait > 0);
      check("cmp_in_ready", in_ready, exp_in_ready());
      if (m_valid) begin
        check("cmp_s", s, m_s);
        check("cmp_co", co, m_co);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_op(input logic [4:0] fc, input logic [W-1:0] ra, input logic [W-1:0] rb, input bit rci);
    bit got;
    @(posedge clk); #2;
    in_valid = 1; f = fc; a = ra; b = rb; ci = rci;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else if (busy) busy_cycles++;
    end
    if (!seen) check("result_timeout", 0, 1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 40));
      1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  logic [4:0]   seq_f [4];
  logic [W-1:0] seq_s [4];
  int           bc;

  initial begin
    rst = 1; in_valid = 0; a = 0; b = 0; ci = 0; f = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    checking = 1;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_s", s, 0);
    check("reset_co", co, 0);

    do_op(ALU_ADD, 32'hFFFF_FFFF, 0, 1);
    @(negedge clk);
    check("add_latency1_valid", out_valid, 1);
    check("add_s", s, 0);
    check("add_co", co, 1);

    do_op(ALU_SUB, 5, 7, 0);
    wait_result(bc);
    check("sub_s", s, 32'hFFFF_FFFE);
    check("sub_borrow", co, 1);

    do_op(ALU_DIV, 100, 7, 0);
    wait_result(bc);
    check("div_busy_cycles", bc, 32);
    check("div_s", s, 14);
    do_op(ALU_MOD, 100, 7, 0);
    wait_result(bc);
    check("mod_s", s, 2);
    do_op(ALU_DIV, 5, 0, 0);
    wait_result(bc);
    check("div0_s", s, 32'hFFFF_FFFF);
    do_op(ALU_MOD, 9, 0, 0);
    wait_result(bc);
    check("mod0_s", s, 9);

    // back-to-back accumulator chain, one op per cycle
    seq_f[0] = ALU_ONE; seq_f[1] = ALU_INC; seq_f[2] = ALU_INC; seq_f[3] = ALU_DEC;
    seq_s[0] = 1;       seq_s[1] = 2;       seq_s[2] = 3;       seq_s[3] = 2;
    @(posedge clk); #2;
    in_valid = 1; f = seq_f[0]; a = 0; b = 0; ci = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (i < 3) f = seq_f[i+1];
      else in_valid = 0;
      @(negedge clk);
      check("chain_valid", out_valid, 1);
      check("chain_s", s, seq_s[i]);
      if (i < 3) check("chain_in_ready", in_ready, 1);
    end

    do_op(ALU_ZERO, 0, 0, 0);
    do_op(ALU_DEC, 0, 0, 0);
    wait_result(bc);
    check("dec_wrap_s", s, 32'hFFFF_FFFF);
    check("dec_wrap_co", co, 1);

    // stall: result must stay put while the next op waits
    @(posedge clk); #2 out_ready = 0;
    do_op(ALU_SHL, 1, 4, 0);
    in_valid = 1; f = ALU_SHL; a = 1; b = 40;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_s", s, 16);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #2;
    end
    out_ready = 1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #2 in_valid = 0;
    @(negedge clk);
    check("shl_big_valid", out_valid, 1);
    check("shl_big_s", s, 0);

    // reset during a divide
    do_op(ALU_ONE, 0, 0, 0);
    do_op(ALU_DIV, 100, 7, 0);
    repeat (9) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_s", s, 0);
    do_op(ALU_NOOP, 0, 0, 0);
    wait_result(bc);
    check("abort_acc_noop", s, 0);

    // randomized traffic, model checks every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      f         = 5'($urandom_range(0, 31));
      a         = rnd_operand();
      b         = rnd_operand();
      ci        = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #2;
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checking = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
